// File: rtl/imem_program_loader_if.sv
// Stream-in and instruction-memory write bus for the program loader.
// The loader sits on the slave side: it sinks the byte stream and drives the memory write port.
interface imem_program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Boot-time instruction-memory writer. Consumes a big-endian byte stream made of a
// 32-bit word-count header followed by that many instruction words, writes them to
// consecutive word addresses from 0, and holds the core in reset until the load is done.
module imem_program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    imem_program_loader_if.slave  bus,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // Memory capacity in words; a header equal to this is still legal.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [1:0]            r_bcnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] r_last;    // header count minus one, i.e. last write address
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_ready;
    logic                  w_acc;
    logic                  w_word_done;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_restart;

    assign w_ready     = (r_state == S_HDR) || (r_state == S_LOAD);
    assign w_acc       = bus.in_valid && w_ready;
    assign w_word_done = w_acc && (r_bcnt == 2'd3);
    // Word as it will look once the byte currently on the bus is shifted in.
    assign w_word      = {r_shift[DATA_WIDTH-9:0], bus.in_data};
    assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    // Sequencer: header capture, byte assembly, one write bubble per word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_index <= '0;
            r_last  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_acc) begin
                r_shift <= w_word;
                r_bcnt  <= r_bcnt + 2'd1;
            end
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_restart) begin
                        r_state <= S_HDR;
                        r_bcnt  <= '0;
                        r_index <= '0;
                    end
                end
                S_HDR: begin
                    if (w_word_done) begin
                        r_index <= '0;
                        r_last  <= ADDR_WIDTH'(w_word - DATA_WIDTH'(1));
                        if (w_word == '0)
                            r_state <= S_DONE;
                        else if ({1'b0, w_word} > CAPACITY)
                            r_state <= S_ERR;
                        else
                            r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_word_done) begin
                        r_state <= S_WRITE;
                        r_addr  <= r_index;
                        r_wdata <= w_word;
                    end
                end
                S_WRITE: begin
                    // Compare before incrementing so a full-capacity load never wraps the index.
                    if (r_index == r_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_index <= r_index + ADDR_WIDTH'(1);
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign cpu_rst = (r_state != S_DONE);
    assign busy    = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done    = (r_state == S_DONE);
    assign error   = (r_state == S_ERR);
endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for the instruction-memory program loader: expected writes are queued as
// words are driven and checked against the writes captured from the memory port.
module tb_imem_program_loader;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst, busy, done, error;

    imem_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rdy_bad = 0;
    int last_edge = 0;
    int first_edge = 0;
    bit aborted = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] obs_q[$];

    logic [31:0] prog[6] = '{32'h02309020, 32'h02309022, 32'h02309024,
                             32'h02309025, 32'hAE720004, 32'h8E740004};

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every memory write; in_ready must be low while writing.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_q.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.in_ready !== 1'b0) rdy_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        int tries;
        if (aborted) return;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        got = 0;
        tries = 0;
        while (!got) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            got = bus.in_ready;
            @(posedge clk);
            tries++;
            if (!got && tries > 40) begin
                n_cmp++; n_fail++;
                $display("FAIL byte_accept: in_ready stayed %b, required 1 within 40 cycles", bus.in_ready);
                aborted = 1;
                return;
            end
        end
        #1 last_edge = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) begin
            send_byte(n[31-8*i -: 8], 0);
            if (i == 0) first_edge = last_edge;
        end
    endtask

    // gapmode: random 0-3 cycle gaps, always at least one between bytes 2 and 3.
    task automatic send_word(input int addr, input logic [31:0] w, input bit gapmode, input bit push);
        int g;
        if (push) exp_q.push_back({AW'(addr), w});
        for (int i = 0; i < 4; i++) begin
            g = 0;
            if (gapmode) begin
                g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                if (i == 2 && g == 0) g = int'($urandom_range(1, 3));
            end
            send_byte(w[31-8*i -: 8], g);
        end
    endtask

    task automatic wait_flag(input int max, output int edge_n);
        edge_n = -1;
        for (int i = 0; i < max; i++) begin
            if (done === 1'b1 || error === 1'b1) begin
                edge_n = cyc;
                return;
            end
            @(negedge clk);
        end
        n_cmp++; n_fail++;
        $display("FAIL wait_flag: done=%b error=%b after %0d cycles, required one of them high", done, error, max);
    endtask

    task automatic check_writes(input string name, input int exp_n);
        logic [AW+31:0] got, want;
        int n;
        n = 0;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_extra_write: got addr=%h data=%h, required no write", name, got[AW+31:32], got[31:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s_write: got addr=%h data=%h, required addr=%h data=%h",
                             name, got[AW+31:32], got[31:0], want[AW+31:32], want[31:0]);
                end
            end
            n++;
        end
        n_cmp++;
        if (n !== exp_n) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d, required %0d", name, n, exp_n);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes: %0d expected writes never seen, required 0", name, exp_q.size());
        end
        n_cmp++;
        if (rdy_bad !== 0) begin
            n_fail++;
            $display("FAIL %s_ready_in_write: in_ready high in %0d write cycles, required 0", name, rdy_bad);
        end
        exp_q.delete();
    endtask

    task automatic check_flags(input string name, input logic [3:0] want);
        n_cmp++;
        if ({cpu_rst, busy, done, error} !== want) begin
            n_fail++;
            $display("FAIL %s_flags: cpu_rst/busy/done/error=%b, required %b", name, {cpu_rst, busy, done, error}, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_flags("reset", 4'b1000);
        n_cmp++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: in_ready=%b mem_we=%b addr=%h wdata=%h, required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int de;
        pulse_start();
        send_hdr(32'd6);
        for (int k = 0; k < 6; k++) send_word(k, prog[k], 0, 1);
        idle();
        wait_flag(100, de);
        n_cmp++;
        if (de - first_edge + 1 !== 34) begin
            n_fail++;
            $display("FAIL nominal_latency: done on cycle %0d after first byte, required 34", de - first_edge + 1);
        end
        check_flags("nominal", 4'b0010);
        check_writes("nominal", 6);
    endtask

    task automatic test_backpressure();
        int de;
        pulse_start();
        send_hdr(32'd6);
        for (int k = 0; k < 6; k++) send_word(k, prog[k], 1, 1);
        idle();
        wait_flag(100, de);
        check_flags("gaps", 4'b0010);
        check_writes("gaps", 6);
    endtask

    task automatic test_empty();
        int de;
        pulse_start();
        send_hdr(32'd0);
        idle();
        wait_flag(20, de);
        n_cmp++;
        if (de !== last_edge) begin
            n_fail++;
            $display("FAIL empty_latency: done at edge %0d, required edge %0d", de, last_edge);
        end
        check_flags("empty", 4'b0010);
        check_writes("empty", 0);
    endtask

    task automatic test_overflow();
        int de;
        pulse_start();
        send_hdr(32'd257);
        idle();
        wait_flag(20, de);
        check_flags("overflow", 4'b1001);
        repeat (3) @(negedge clk);
        check_writes("overflow", 0);
        pulse_start();
        check_flags("err_restart", 4'b1100);
    endtask

    task automatic test_full();
        int de;
        pulse_start();
        send_hdr(32'd256);
        for (int k = 0; k < 256; k++) send_word(k, $urandom, 0, 1);
        idle();
        wait_flag(100, de);
        check_flags("full", 4'b0010);
        check_writes("full", 256);
    endtask

    task automatic test_reset_midload();
        int de;
        pulse_start();
        send_hdr(32'd6);
        send_word(0, prog[0], 0, 1);
        send_word(1, prog[1], 0, 1);
        send_byte(prog[2][31:24], 0);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_flags("midload_rst", 4'b1000);
        n_cmp++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL midload_rst_bus: in_ready=%b mem_we=%b addr=%h wdata=%h, required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        check_writes("midload_partial", 2);
        pulse_start();
        send_hdr(32'd6);
        for (int k = 0; k < 6; k++) send_word(k, prog[k], 0, 1);
        idle();
        wait_flag(100, de);
        check_flags("midload_reload", 4'b0010);
        check_writes("midload_reload", 6);
    endtask

    task automatic test_reload_and_start_ignored();
        int de;
        pulse_start();
        check_flags("reload_start", 4'b1100);
        send_hdr(32'd1);
        send_word(0, 32'h00000020, 0, 1);
        idle();
        wait_flag(40, de);
        check_flags("reload", 4'b0010);
        check_writes("reload", 1);

        pulse_start();
        send_hdr(32'd2);
        send_word(0, 32'h8C010000, 0, 1);
        send_byte(8'hAC, 0);
        exp_q.push_back({AW'(1), 32'hAC220004});
        pulse_start();
        check_flags("start_in_load", 4'b1100);
        send_byte(8'h22, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        idle();
        wait_flag(40, de);
        check_flags("start_ignored", 4'b0010);
        check_writes("start_ignored", 2);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_empty();
        test_overflow();
        test_full();
        test_reset_midload();
        test_reload_and_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Boot-time writer for the MIPS instruction memory.
- Receives a byte stream over a valid/ready interface. The stream is a 32-bit word-count header followed by that many 32-bit instruction words.
- Writes each assembled word into instruction memory at consecutive word addresses starting at 0.
- Holds the processor in reset until the load completes. This replaces loading instruction memory by hierarchical testbench assignment with a synthesizable path.

Parameters:
- ADDR_WIDTH, 8: instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: instruction word width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte; most significant byte of each word first.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable; one-cycle pulse.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  instruction word to write.
- cpu_rst  output  1  reset to the MIPS core; high = core held.
- busy  output  1  load in progress (HDR, LOAD or WRITE).
- done  output  1  load finished successfully.
- error  output  1  header word count exceeded capacity.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE; byte count, word index and header count cleared.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst=1, busy=0, done=0, error=0.
  - rst overrides every state, including mid-load. A partially written memory is not cleaned up.
- Byte transfer: a byte is accepted only when in_valid=1 and in_ready=1 on the same edge. in_data may change freely while in_valid=0.
- Byte assembly:
  - A 2-bit byte counter shifts bytes into a 32-bit shift register, big-endian: first byte goes to [31:24], fourth byte to [7:0].
  - The counter wraps 3->0 on the fourth byte.
- States:
  - IDLE: in_ready=0. start -> HDR.
  - HDR: in_ready=1. On the 4th accepted byte, latch word count N (32 bits).
    - N=0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERR.
    - Otherwise -> LOAD with index=0.
  - LOAD: in_ready=1. On the 4th accepted byte -> WRITE, with mem_wdata = the assembled word.
  - WRITE:
    - in_ready=0; mem_we=1 for exactly this one cycle; mem_addr=index.
    - If index==N-1 -> DONE, else index+1 and -> LOAD.
    - Write latency: mem_we is high in the cycle immediately after the edge that accepted the word's 4th byte.
  - DONE: done=1, cpu_rst=0, in_ready=0. start -> HDR, with cpu_rst=1 and done=0 from the next cycle.
  - ERR: error=1, cpu_rst=1, in_ready=0. start -> HDR, clears error.
- Outputs by state:
  - cpu_rst=1 in every state except DONE.
  - busy=1 exactly in HDR, LOAD and WRITE.
  - done and error are never both high.
- start is ignored in HDR, LOAD and WRITE.
- When start arrives in IDLE, DONE or ERR, the byte counter and index are cleared on that transition.
- The N=2^ADDR_WIDTH boundary is legal: the last write goes to address 2^ADDR_WIDTH-1, and the index never wraps.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Stall behaviour: in_valid gaps of any length stall the loader with no timeout. The byte counter holds across gaps.
- Throughput: one byte per cycle in HDR and LOAD, plus one WRITE bubble per word. N words take 4+5N cycles minimum from the first header byte to DONE.

Test Plan:
- Nominal load: start, header 00 00 00 06, then bytes of 02309020, 02309022, 02309024, 02309025, AE720004, 8E740004 with in_valid held high.
  - Expect six mem_we pulses at addr 0..5 with exactly those words.
  - Expect done=1 and cpu_rst=0 on cycle 4+5*6=34 after the first accepted byte.
- Backpressure and gaps: same stream with in_valid dropped for 1-3 cycles at random points, including between byte 2 and byte 3 of a word.
  - Expect identical memory writes and no extra mem_we.
  - Expect in_ready=0 during each WRITE cycle.
- Empty program: header 00 00 00 00.
  - Expect DONE the cycle after the 4th header byte, zero mem_we pulses, cpu_rst=0.
- Capacity limits with ADDR_WIDTH=8:
  - Header 00 00 01 01 (257): expect ERR, error=1, cpu_rst=1, no writes.
  - Header 00 00 01 00 (256): expect 256 writes, last at addr 0xFF, then DONE.
- Reset mid-load: assert rst during LOAD after word 2, byte 1.
  - Expect IDLE next cycle with all outputs at reset values.
  - A fresh start plus the full stream reloads correctly from addr 0.
- Reload from DONE, and start ignored in LOAD:
  - In DONE, pulse start and send header 00 00 00 01 plus word 00000020: expect cpu_rst=1 again, a single write at addr 0, then DONE.
  - A start pulse asserted during LOAD has no effect on the sequence.
